// File: rtl/moving_average_n.sv
// moving_average_n: streaming 2^LOG2_DEPTH-sample moving average using a running sum and a delay line.
// Define MOVAVG_ROUND_EN to get round-half-up on out_data instead of floor.
module moving_average_n #(
    parameter int DATA_W     = 8,
    parameter int LOG2_DEPTH = 2,
    localparam int SUM_W     = DATA_W + LOG2_DEPTH
) (
    input  logic                     system1000,
    input  logic                     system1000_rstn,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_data,
    output logic signed [SUM_W-1:0]  out_sum,
    output logic                     out_full
);
    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam logic [LOG2_DEPTH:0] DEPTH_C = (LOG2_DEPTH + 1)'(DEPTH);

    logic signed [DATA_W-1:0] dly_q [DEPTH];
    logic signed [SUM_W-1:0]  sum_q, sum_d;
    logic [LOG2_DEPTH:0]      fill_q, fill_d;
    logic signed [DATA_W-1:0] mean_q, mean_d;
    logic                     valid_q, full_q;

    // Zero-filled empty slots make the subtraction correct while the window fills.
    assign sum_d  = sum_q + SUM_W'(in_data) - SUM_W'(dly_q[DEPTH-1]);
    assign fill_d = (fill_q == DEPTH_C) ? fill_q : fill_q + 1'b1;

`ifdef MOVAVG_ROUND_EN
    localparam logic signed [SUM_W:0] HALF  = (SUM_W + 1)'((1 << LOG2_DEPTH) >> 1);
    localparam logic signed [SUM_W:0] MAX_V = (SUM_W + 1)'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [SUM_W:0] MIN_V = -MAX_V - 1;
    logic signed [SUM_W:0] rnd;
    assign rnd    = ((SUM_W + 1)'(sum_d) + HALF) >>> LOG2_DEPTH;
    assign mean_d = (rnd > MAX_V) ? DATA_W'(MAX_V) : (rnd < MIN_V) ? DATA_W'(MIN_V) : DATA_W'(rnd);
`else
    assign mean_d = DATA_W'(sum_d >>> LOG2_DEPTH);
`endif

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            for (int i = 0; i < DEPTH; i++) dly_q[i] <= '0;
            sum_q   <= '0;
            fill_q  <= '0;
            mean_q  <= '0;
            valid_q <= 1'b0;
            full_q  <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) dly_q[i] <= '0;
            sum_q   <= '0;
            fill_q  <= '0;
            mean_q  <= '0;
            valid_q <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                dly_q[0] <= in_data;
                for (int i = 1; i < DEPTH; i++) dly_q[i] <= dly_q[i-1];
                sum_q  <= sum_d;
                fill_q <= fill_d;
                mean_q <= mean_d;
                full_q <= (fill_d == DEPTH_C);
            end
        end
    end

    assign out_valid = valid_q;
    assign out_data  = mean_q;
    assign out_sum   = sum_q;
    assign out_full  = full_q;
endmodule

// File: doc/moving_average_n.md
Name: moving_average_n

Overview:
- Parametrised streaming moving-average filter over a window of 2^LOG2_DEPTH signed samples.
- Keeps a running sum: add the newest sample, subtract the one leaving the window; no adder tree.
- Adds a valid qualifier, synchronous clear, fill tracking, a full-precision sum output and registered outputs.
- Sits in the same datapath slot as the fixed 4-tap, 8-bit, always-enabled averager; generalises it.

Parameters:
- DATA_W, 8, signed sample width (>=2).
- LOG2_DEPTH, 2, log2 of window length; DEPTH = 2^LOG2_DEPTH (1..8).
- SUM_W (derived localparam, not overridable), DATA_W+LOG2_DEPTH, running-sum width; wide enough that the sum never overflows.

Ports:
- system1000  in  1  clock, rising edge.
- system1000_rstn  in  1  reset system1000_rstn, asynchronous, active-low.
- clear  in  1  synchronous flush of window, sum and fill count.
- in_valid  in  1  in_data is consumed this cycle.
- in_data  in  DATA_W  signed sample.
- out_valid  out  1  one-cycle pulse: out_data/out_sum updated.
- out_data  out  DATA_W  signed window mean.
- out_sum  out  SUM_W  signed window sum.
- out_full  out  1  DEPTH samples accepted since last reset/clear.

Behaviour:
- Reset (async assert, sync release): delay line all 0, sum 0, fill count 0, out_valid 0, out_data 0, out_sum 0, out_full 0.
- Delay line buf[0..DEPTH-1] of signed DATA_W; buf[DEPTH-1] is the oldest sample.
- Empty slots hold 0, so the window is zero-padded until full.
- On a cycle with in_valid=1 and clear=0:
  - sum_n = sum + sext(in_data) - sext(buf[DEPTH-1]), computed exactly in SUM_W.
  - buf shifts one place (buf[0] <= in_data); sum <= sum_n.
  - fill count increments, saturating at DEPTH.
- The window includes the current sample, matching the predecessor.
- Latency is 1 cycle. On the edge after the accepting cycle:
  - out_valid=1, out_sum=sum_n.
  - out_data = sum_n >>> LOG2_DEPTH (arithmetic shift, floor), truncated to DATA_W.
  - The mean of DEPTH DATA_W values always fits DATA_W, so truncation never loses magnitude.
- in_valid=0: state holds, out_valid=0, out_data/out_sum keep last value.
- out_full = (fill count == DEPTH), registered. It rises together with the out_valid of the DEPTH-th accepted sample.
- clear=1 (wins over in_valid): buf, sum and fill count go to 0; out_valid=0, out_full=0; out_data and out_sum go to 0. Any in_data on that cycle is dropped.
- Back-to-back in_valid is supported at full rate, one sample per clock; no backpressure.
- Reset asserted mid-stream: all state is cleared immediately, and the first sample after release starts an empty window.
- LOG2_DEPTH=0: pass-through with 1-cycle latency; out_sum = sext(in_data).

Optional Feature:
- Macro: MOVAVG_ROUND_EN.
- Defined: out_data = (sum_n + 2^(LOG2_DEPTH-1)) >>> LOG2_DEPTH, i.e. round half up. The rounding add is done at SUM_W+1 bits, then saturated to the DATA_W range. Ignored when LOG2_DEPTH=0.
- Undefined: floor (plain arithmetic shift), no adder.
- out_sum is identical in both builds.

Test Plan (DATA_W=8, LOG2_DEPTH=2 unless stated):
- Fill: in_data 4,8,12,16,20 on consecutive cycles -> out_sum 4,12,24,40,56; out_data 1,3,6,10,14; out_full first high with sum 40; out_valid high 5 cycles.
- Gaps: in_valid pattern 1,0,0,1 with data 10,x,x,10 -> two out_valid pulses; out_sum 10 then 20; outputs stable during gaps.
- Extremes: 4x 127 -> out_sum 508, out_data 127. Then 4x -128 -> out_sum -512, out_data -128. No wrap.
- Negative rounding: single -1 from empty -> out_sum -1; out_data -1 (floor) or 0 with MOVAVG_ROUND_EN. Single 6 -> out_data 1, or 2 with MOVAVG_ROUND_EN.
- Clear: after 3 samples of 20, clear=1 with in_valid=1, data 99 -> next cycle all outputs 0. Then sample 8 -> out_sum 8, out_full 0.
- Reset mid-stream: drop system1000_rstn between samples -> outputs 0 asynchronously. After release, sample 5 -> out_sum 5.
